// File: rtl/seg_7_rx.sv
// Receiver for the multiplexed 7-segment bus: synchronises seg/com, waits for each
// pair to settle, decodes it to BCD per position and flags complete four-digit frames.
module seg_7_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  com_in,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [3:0]  digit_vld,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic        err,
  output logic        err_sticky
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] val;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] s);
    dec_t d;
    d    = '0;
    d.ok = 1'b1;
    case (s)
      7'h7E:   d.val = 4'd0;
      7'h30:   d.val = 4'd1;
      7'h6D:   d.val = 4'd2;
      7'h79:   d.val = 4'd3;
      7'h33:   d.val = 4'd4;
      7'h5B:   d.val = 4'd5;
      7'h5F:   d.val = 4'd6;
      7'h70:   d.val = 4'd7;
      7'h7F:   d.val = 4'd8;
      7'h7B:   d.val = 4'd9;
      7'h00: begin
        d.blank = 1'b1;
        d.val   = 4'hF;
      end
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

  logic [6:0]       r_seg_m, r_seg_s;
  logic [3:0]       r_com_m, r_com_s;
  logic [10:0]      r_p;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [3:0]       r_mask;

  logic [10:0]      w_p;
  logic             w_chg, w_onehot, w_multi, w_fire, w_cap, w_err_ev;
  logic [CNT_W-1:0] w_cnt_nxt;
  state_t           w_state_nxt;
  logic [1:0]       w_idx;
  logic [3:0]       w_mask_set;
  dec_t             w_dec;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '0;
      r_seg_s <= '0;
      r_com_m <= '0;
      r_com_s <= '0;
      r_p     <= '0;
    end else begin
      r_seg_m <= seg_in;
      r_seg_s <= r_seg_m;
      r_com_m <= com_in;
      r_com_s <= r_com_m;
      r_p     <= w_p;
    end
  end

  assign w_p      = {r_seg_s, r_com_s};
  assign w_chg    = (w_p != r_p);
  assign w_onehot = $onehot(r_com_s);
  assign w_multi  = (r_com_s != 4'b0000) && !w_onehot;
  assign w_dec    = decode(r_seg_s);

  // The counter tracks consecutive identical samples of P, whatever the state.
  assign w_cnt_nxt = w_chg ? CNT_W'(1) : ((r_cnt == STABLE) ? r_cnt : r_cnt + 1'b1);
  assign w_fire    = (w_cnt_nxt == STABLE) && (w_chg || (r_cnt != STABLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_err_ev    = w_multi && w_fire;
    if (w_chg) begin
      if (!w_onehot)   w_state_nxt = IDLE;
      else if (w_fire) w_state_nxt = HOLD;
      else             w_state_nxt = SETTLE;
      w_cap = w_onehot && w_fire;
    end else if (r_state == SETTLE && w_fire) begin
      w_state_nxt = HOLD;
      w_cap       = 1'b1;
    end
  end

  always_comb begin
    w_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (r_com_s[k]) w_idx = 2'(k);
    end
  end

  assign w_mask_set = r_mask | (4'b0001 << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits     <= '0;
      digit_vld  <= '0;
      blank      <= '0;
      r_mask     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      digits     <= '0;
      digit_vld  <= '0;
      blank      <= '0;
      r_mask     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (w_err_ev) begin
        err        <= 1'b1;
        err_sticky <= 1'b1;
      end
      if (w_cap) begin
        if (!w_dec.ok) begin
          digit_vld[w_idx] <= 1'b0;
          blank[w_idx]     <= 1'b0;
          err              <= 1'b1;
          err_sticky       <= 1'b1;
        end else begin
          digits[{w_idx, 2'b00} +: 4] <= w_dec.val;
          digit_vld[w_idx]            <= 1'b1;
          blank[w_idx]                <= w_dec.blank;
          if (w_mask_set == 4'hF) begin
            frame_done <= 1'b1;
            r_mask     <= 4'h0;
          end else begin
            r_mask <= w_mask_set;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_7_rx.sv
// Bench for seg_7_rx: drives segment/common pairs, predicts each capture from a
// reference decode table and compares outputs on the predicted capture edge.
module tb_seg_7_rx;

  localparam int ST  = 4;
  localparam int LAT = ST + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  com_in;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  digit_vld;
  logic [3:0]  blank;
  logic        frame_done;
  logic        err;
  logic        err_sticky;

  seg_7_rx #(.STABLE_CYCLES(ST), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .com_in     (com_in),
    .clr        (clr),
    .digits     (digits),
    .digit_vld  (digit_vld),
    .blank      (blank),
    .frame_done (frame_done),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    int         pos;
    logic [3:0] pre_dig, post_dig;
    logic       pre_vld, post_vld, pre_blk, post_blk;
    logic       frm, er;
  } exp_t;

  exp_t q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int n_frm = 0, n_err = 0, exp_frm = 0, exp_err = 0;

  logic [3:0] m_dig [4];
  logic [3:0] m_vld, m_blk, m_mask;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) n_frm++;
    if (err) n_err++;
    if (q.size() != 0) begin
      e = q[0];
      if (e.pos >= 0 && cyc == e.edge_no - 1) begin
        total++;
        if ({digits[e.pos*4 +: 4], digit_vld[e.pos], blank[e.pos]} !==
            {e.pre_dig, e.pre_vld, e.pre_blk}) begin
          bad++;
          $display("FAIL early_capture pos=%0d edge=%0d got dig=%h vld=%b blk=%b want dig=%h vld=%b blk=%b",
                   e.pos, cyc, digits[e.pos*4 +: 4], digit_vld[e.pos], blank[e.pos],
                   e.pre_dig, e.pre_vld, e.pre_blk);
        end
      end
      if (cyc == e.edge_no) begin
        if (e.pos >= 0) begin
          total++;
          if ({digits[e.pos*4 +: 4], digit_vld[e.pos], blank[e.pos]} !==
              {e.post_dig, e.post_vld, e.post_blk}) begin
            bad++;
            $display("FAIL capture pos=%0d edge=%0d got dig=%h vld=%b blk=%b want dig=%h vld=%b blk=%b",
                     e.pos, cyc, digits[e.pos*4 +: 4], digit_vld[e.pos], blank[e.pos],
                     e.post_dig, e.post_vld, e.post_blk);
          end
        end
        total++;
        if ({frame_done, err} !== {e.frm, e.er}) begin
          bad++;
          $display("FAIL pulses edge=%0d got frame_done=%b err=%b want frame_done=%b err=%b",
                   cyc, frame_done, err, e.frm, e.er);
        end
        void'(q.pop_front());
      end else if (cyc > e.edge_no) begin
        total++;
        bad++;
        $display("FAIL missed_edge expected edge=%0d now=%0d", e.edge_no, cyc);
        void'(q.pop_front());
      end
    end
  end

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    case (s)
      7'h7E: return {2'b10, 4'd0};
      7'h30: return {2'b10, 4'd1};
      7'h6D: return {2'b10, 4'd2};
      7'h79: return {2'b10, 4'd3};
      7'h33: return {2'b10, 4'd4};
      7'h5B: return {2'b10, 4'd5};
      7'h5F: return {2'b10, 4'd6};
      7'h70: return {2'b10, 4'd7};
      7'h7F: return {2'b10, 4'd8};
      7'h7B: return {2'b10, 4'd9};
      7'h00: return {2'b11, 4'hF};
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int com_pos(input logic [3:0] c);
    for (int k = 0; k < 4; k++) if (c == (4'b0001 << k)) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
    m_vld  = '0;
    m_blk  = '0;
    m_mask = '0;
  endtask

  task automatic show(input logic [6:0] s, input logic [3:0] c, input int hold);
    exp_t e;
    logic [5:0] d;
    logic [3:0] set;
    int p;
    @(negedge clk);
    seg_in = s;
    com_in = c;
    p = com_pos(c);
    if (hold >= ST && c != 4'b0000) begin
      e.edge_no = cyc + LAT;
      e.pos     = p;
      e.frm     = 1'b0;
      e.er      = 1'b0;
      e.pre_dig = 4'h0; e.pre_vld = 1'b0; e.pre_blk = 1'b0;
      if (p >= 0) begin
        d = ref_decode(s);
        e.pre_dig = m_dig[p]; e.pre_vld = m_vld[p]; e.pre_blk = m_blk[p];
        if (d[5]) begin
          m_dig[p] = d[3:0];
          m_vld[p] = 1'b1;
          m_blk[p] = d[4];
          set = m_mask | (4'b0001 << p);
          if (set == 4'hF) begin
            e.frm = 1'b1;
            exp_frm++;
            m_mask = 4'h0;
          end else begin
            m_mask = set;
          end
        end else begin
          m_vld[p] = 1'b0;
          m_blk[p] = 1'b0;
          e.er = 1'b1;
          exp_err++;
        end
      end else begin
        e.er = 1'b1;
        exp_err++;
      end
      e.post_dig = (p >= 0) ? m_dig[p] : 4'h0;
      e.post_vld = (p >= 0) ? m_vld[p] : 1'b0;
      e.post_blk = (p >= 0) ? m_blk[p] : 1'b0;
      q.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic gap();
    show(7'h00, 4'b0000, 3);
  endtask

  task automatic drain_and_count(input string name);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d want 0", name, q.size());
      q.delete();
    end
    total++;
    if (n_frm !== exp_frm || n_err !== exp_err) begin
      bad++;
      $display("FAIL %s_pulse_count got frames=%0d errs=%0d want frames=%0d errs=%0d",
               name, n_frm, n_err, exp_frm, exp_err);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({digits, digit_vld, blank, frame_done, err, err_sticky} !== 27'd0) begin
      bad++;
      $display("FAIL %s got digits=%h vld=%b blank=%b fd=%b err=%b sticky=%b want all 0",
               name, digits, digit_vld, blank, frame_done, err, err_sticky);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; seg_in = '0; com_in = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    show(7'h7E, 4'b0001, 10); gap();
    show(7'h30, 4'b0010, 10); gap();
    show(7'h6D, 4'b0100, 10); gap();
    show(7'h79, 4'b1000, 10); gap();
    drain_and_count("scan");
    total++;
    if ({digits, digit_vld} !== {16'h3210, 4'hF}) begin
      bad++;
      $display("FAIL scan_result got digits=%h vld=%b want 3210 1111", digits, digit_vld);
    end
  endtask

  task automatic test_settle();
    show(7'h5B, 4'b0100, 3);
    show(7'h33, 4'b0100, 10);
    gap();
    drain_and_count("settle");
    total++;
    if (digits[11:8] !== 4'd4 || err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL settle_result got pos2=%h sticky=%b want 4 0", digits[11:8], err_sticky);
    end
  endtask

  task automatic test_invalid();
    show(7'h12, 4'b0001, 10);
    drain_and_count("invalid");
    total++;
    if (err_sticky !== 1'b1 || digit_vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL invalid_sticky got sticky=%b vld0=%b want 1 0", err_sticky, digit_vld[0]);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
    check_all_zero("clr_result");
    gap();
  endtask

  task automatic test_multi_blank();
    show(7'h7E, 4'b0011, 10); gap();
    drain_and_count("multi_hot");
    total++;
    if ({digits, digit_vld} !== 20'd0 || err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL multi_hot_result got digits=%h vld=%b sticky=%b want 0 0 1",
               digits, digit_vld, err_sticky);
    end
    show(7'h00, 4'b1000, 10); gap();
    drain_and_count("blank");
    total++;
    if ({digits[15:12], digit_vld[3], blank[3]} !== {4'hF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL blank_result got dig3=%h vld3=%b blank3=%b want F 1 1",
               digits[15:12], digit_vld[3], blank[3]);
    end
  endtask

  task automatic test_reset_mid();
    show(7'h7E, 4'b0001, 10); gap();
    show(7'h30, 4'b0010, 10); gap();
    show(7'h6D, 4'b0100, 10); gap();
    drain_and_count("pre_reset");
    @(negedge clk); seg_in = 7'h79; com_in = 4'b1000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_settle");
    q.delete();
    model_clear();
    seg_in = '0; com_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    show(7'h7F, 4'b0001, 10); gap();
    show(7'h7B, 4'b0010, 10); gap();
    show(7'h5F, 4'b0100, 10); gap();
    show(7'h70, 4'b1000, 10); gap();
    drain_and_count("post_reset_scan");
    total++;
    if ({digits, digit_vld} !== {16'h7698, 4'hF}) begin
      bad++;
      $display("FAIL post_reset_result got digits=%h vld=%b want 7698 1111", digits, digit_vld);
    end
  endtask

  task automatic test_clr_on_capture();
    exp_t e;
    show(7'h7E, 4'b0001, 10); gap();
    show(7'h30, 4'b0010, 10); gap();
    drain_and_count("pre_clr");
    @(negedge clk); seg_in = 7'h6D; com_in = 4'b0100;
    e.edge_no = cyc + LAT;
    e.pos = 2;
    e.pre_dig = m_dig[2]; e.pre_vld = m_vld[2]; e.pre_blk = m_blk[2];
    e.post_dig = 4'h0; e.post_vld = 1'b0; e.post_blk = 1'b0;
    e.frm = 1'b0; e.er = 1'b0;
    q.push_back(e);
    model_clear();
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    repeat (6) @(negedge clk);
    drain_and_count("clr_capture");
    total++;
    if ({digits, digit_vld, blank} !== 24'd0) begin
      bad++;
      $display("FAIL no_recapture got digits=%h vld=%b blank=%b want 0 0 0", digits, digit_vld, blank);
    end
    gap();
    show(7'h6D, 4'b0100, 10); gap();
    drain_and_count("recapture");
    total++;
    if ({digits, digit_vld} !== {16'h0200, 4'b0100}) begin
      bad++;
      $display("FAIL recapture_result got digits=%h vld=%b want 0200 0100", digits, digit_vld);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_settle();
    test_invalid();
    test_multi_blank();
    test_reset_mid();
    test_clr_on_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
